uart_tx_arbiter: RTL and testbench

Sequencer/arbiter that shares the single UART transmitter among NUM_REQ on-chip requesters, such as the ALU-result path and the register-read path. It sits between the system controller's requesters and the UART TX input side. It accepts one- or two-byte transfers, presents bytes one at a time on P_DATA with a one-cycle DATA_VALID pulse, and paces transfers using the transmitter's Busy output. It signals grant and completion per requester, and flags a transmitter that never acknowledges.

---
 rtl/uart_tx_arb_pkg.sv | 11 +
 rtl/uart_tx_arb_picker.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and constants for the UART TX arbiter
//   state_t     : controller FSM states
//   BYTE_W      : width of one byte sent to the transmitter
//   WORD_W      : width of a requester word (up to two bytes)
//   NUM_REQ_DEF : default number of requesters
package uart_tx_arb_pkg;
   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
   localparam int BYTE_W      = 8;
   localparam int WORD_W      = 16;
   localparam int NUM_REQ_DEF = 2;
endpackage

// File: rtl/uart_tx_arb_picker.sv
// uart_tx_arb_picker: combinational winner select among pending requests
//   req : request vector
//   ptr : first index searched (present only with TX_ARB_ROUND_ROBIN_EN)
//   gnt : one-hot winner, all zero when nothing requests
//   idx : binary winner index
// TX_ARB_ROUND_ROBIN_EN defined: search starts at ptr and wraps; otherwise
// fixed priority with the lowest index winning.
module uart_tx_arb_picker
   import uart_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
`ifdef TX_ARB_ROUND_ROBIN_EN
   input  logic [IW-1:0]      ptr,
`endif
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);
`ifdef TX_ARB_ROUND_ROBIN_EN
   logic [IW:0] j;
`endif
   // Scanning from the far end lets the candidate nearest the start win.
   always_comb begin
      idx = '0;
`ifdef TX_ARB_ROUND_ROBIN_EN
      j = '0;
`endif
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
         j = {1'b0, ptr} + (IW+1)'(k);
         if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
         if (req[j[IW-1:0]]) idx = j[IW-1:0];
`else
         if (req[k]) idx = IW'(k);
`endif
      end
      gnt = |req ? NUM_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ requesters
//   CLK, RST     : clock, synchronous active-high reset
//   REQ          : per-requester level request, held until GNT
//   REQ_DATA     : per-requester 16-bit word, byte 0 in the low bits
//   REQ_TWO_BYTE : per-requester, 1 sends both bytes
//   GNT, DONE    : per-requester one-cycle grant / completion pulses
//   P_DATA       : byte to the transmitter, held outside SEND
//   DATA_VALID   : one-cycle start strobe to the transmitter
//   TX_BUSY      : transmitter busy
//   CTRL_BUSY    : high whenever the controller is not idle
//   ERR_TIMEOUT  : sticky flag, a byte was never acknowledged
// TX_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed
// lowest-index priority.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        REQ,
   input  logic [WORD_W*NUM_REQ-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]        REQ_TWO_BYTE,
   output logic [NUM_REQ-1:0]        GNT,
   output logic [NUM_REQ-1:0]        DONE,
   output logic [BYTE_W-1:0]         P_DATA,
   output logic                      DATA_VALID,
   input  logic                      TX_BUSY,
   output logic                      CTRL_BUSY,
   output logic                      ERR_TIMEOUT
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   state_t              state;
   logic [NUM_REQ-1:0]  pick_oh;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       win;
   logic [BYTE_W-1:0]   hi_byte;
   logic                two;
   logic                bptr;
   logic [CW-1:0]       cnt;
   logic                start;
   assign start     = (state == IDLE) && |REQ && !TX_BUSY;
   assign CTRL_BUSY = (state != IDLE);
`ifdef TX_ARB_ROUND_ROBIN_EN
   logic [IW-1:0] rr_ptr;
   uart_tx_arb_picker #(.NUM_REQ(NUM_REQ)) picker (
      .req(REQ),
      .ptr(rr_ptr),
      .gnt(pick_oh),
      .idx(pick_idx)
   );
   // Next search starts just past the requester that was granted.
   always_ff @(posedge CLK)
      if (RST) rr_ptr <= '0;
      else if (start) rr_ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
`else
   uart_tx_arb_picker #(.NUM_REQ(NUM_REQ)) picker (
      .req(REQ),
      .gnt(pick_oh),
      .idx(pick_idx)
   );
`endif
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         GNT         <= '0;
         DONE        <= '0;
         P_DATA      <= '0;
         DATA_VALID  <= 1'b0;
         ERR_TIMEOUT <= 1'b0;
         win         <= '0;
         hi_byte     <= '0;
         two         <= 1'b0;
         bptr        <= 1'b0;
         cnt         <= '0;
      end else begin
         GNT        <= '0;
         DONE       <= '0;
         DATA_VALID <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  win        <= pick_idx;
                  hi_byte    <= REQ_DATA[pick_idx*WORD_W+BYTE_W +: BYTE_W];
                  two        <= REQ_TWO_BYTE[pick_idx];
                  bptr       <= 1'b0;
                  GNT        <= pick_oh;
                  P_DATA     <= REQ_DATA[pick_idx*WORD_W +: BYTE_W];
                  DATA_VALID <= 1'b1;
                  state      <= SEND;
               end
            SEND: begin
               cnt   <= '0;
               state <= WAIT_ACK;
            end
            // cnt holds cycles already spent here, so the last allowed cycle
            // is ACK_TIMEOUT-1 and DONE lands ACK_TIMEOUT+1 after DATA_VALID.
            WAIT_ACK:
               if (TX_BUSY) state <= WAIT_DONE;
               else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                  ERR_TIMEOUT <= 1'b1;
                  DONE[win]   <= 1'b1;
                  state       <= IDLE;
               end else cnt <= cnt + CW'(1);
            WAIT_DONE:
               if (!TX_BUSY) begin
                  if (two && !bptr) begin
                     bptr       <= 1'b1;
                     P_DATA     <= hi_byte;
                     DATA_VALID <= 1'b1;
                     state      <= SEND;
                  end else begin
                     DONE[win] <= 1'b1;
                     state     <= IDLE;
                  end
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
   localparam int A = 16;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [31:0] req_data;
   logic [1:0]  two;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [7:0]  p_data;
   logic        dv;
   logic        tx_busy;
   logic        ctrl_busy;
   logic        err;
   int          passed = 0;
   int          total  = 0;
   int          dv_n;
   int          done_n;
   logic [1:0]  exp_g [4];

   uart_tx_arbiter #(.NUM_REQ(2), .ACK_TIMEOUT(A)) dut (
      .CLK(clk),
      .RST(rst),
      .REQ(req),
      .REQ_DATA(req_data),
      .REQ_TWO_BYTE(two),
      .GNT(gnt),
      .DONE(done),
      .P_DATA(p_data),
      .DATA_VALID(dv),
      .TX_BUSY(tx_busy),
      .CTRL_BUSY(ctrl_busy),
      .ERR_TIMEOUT(err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pdata"}, 32'(p_data), 0);
      chk({tag, "_dv"}, 32'(dv), 0);
      chk({tag, "_cbusy"}, 32'(ctrl_busy), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
`ifdef TX_ARB_ROUND_ROBIN_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      rst = 1'b1; req = '0; req_data = '0; two = '0; tx_busy = 1'b0;
      tick; tick;
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick;
      // single byte from requester 0
      req = 2'b01; req_data = 32'h0000_00A5; two = 2'b00;
      tick;
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_dv", 32'(dv), 1);
      chk("t1_pdata", 32'(p_data), 32'hA5);
      chk("t1_cbusy", 32'(ctrl_busy), 1);
      req = '0;
      tick;
      tx_busy = 1'b1;
      dv_n = 0; done_n = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         dv_n += int'(dv);
         done_n += int'(|done);
      end
      chk("t1_dv_busy", 32'(dv_n), 0);
      chk("t1_done_busy", 32'(done_n), 0);
      tx_busy = 1'b0;
      tick;
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_pdata_hold", 32'(p_data), 32'hA5);
      chk("t1_idle", 32'(ctrl_busy), 0);
      tick;
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_err", 32'(err), 0);
      // two bytes from requester 1
      req = 2'b10; req_data = 32'h3C7E_0000; two = 2'b10;
      tick;
      chk("t2_gnt", 32'(gnt), 32'h2);
      chk("t2_dv1", 32'(dv), 1);
      chk("t2_pd1", 32'(p_data), 32'h7E);
      req = '0;
      tick;
      tx_busy = 1'b1;
      tick;
      tick; tick; tick;
      chk("t2_no_dv_busy", 32'(dv), 0);
      tx_busy = 1'b0;
      tick;
      chk("t2_dv2", 32'(dv), 1);
      chk("t2_pd2", 32'(p_data), 32'h3C);
      chk("t2_no_early_done", 32'(done), 0);
      tick;
      chk("t2_dv2_pulse", 32'(dv), 0);
      tx_busy = 1'b1;
      tick;
      tx_busy = 1'b0;
      tick;
      chk("t2_done", 32'(done), 32'h2);
      // contention, both requesters held
      req = 2'b11; req_data = 32'h0022_0011; two = 2'b00;
      for (int n = 0; n < 4; n++) begin
         tick;
         chk($sformatf("t3_gnt%0d", n), 32'(gnt), 32'(exp_g[n]));
         tick;
         tx_busy = 1'b1;
         tick;
         tx_busy = 1'b0;
         tick;
         chk($sformatf("t3_done%0d", n), 32'(done), 32'(exp_g[n]));
      end
      req = '0;
      tick;
      // timeout: transmitter never acknowledges
      tx_busy = 1'b0; req = 2'b01; req_data = 32'h0000_1234; two = 2'b01;
      tick;
      chk("t4_gnt", 32'(gnt), 32'h1);
      chk("t4_pd", 32'(p_data), 32'h34);
      req = '0;
      dv_n = 0; done_n = 0;
      for (int k = 1; k <= A; k++) begin
         tick;
         dv_n += int'(dv);
         done_n += int'(|done);
      end
      chk("t4_no_early_done", 32'(done_n), 0);
      tick;
      chk("t4_done", 32'(done), 32'h1);
      chk("t4_err", 32'(err), 1);
      for (int k = 0; k < 5; k++) begin
         tick;
         dv_n += int'(dv);
      end
      chk("t4_single_dv", 32'(dv_n), 0);
      chk("t4_err_sticky", 32'(err), 1);
      // reset while in WAIT_DONE
      req = 2'b01; req_data = 32'h0000_BEEF; two = 2'b01;
      tick;
      chk("t5_gnt", 32'(gnt), 32'h1);
      req = '0;
      tick;
      tx_busy = 1'b1;
      tick;
      chk("t5_busy", 32'(ctrl_busy), 1);
      rst = 1'b1;
      tick;
      chk_reset_outputs("t5_rst");
      rst = 1'b0; tx_busy = 1'b0;
      tick;
      chk("t5_no_done", 32'(done), 0);
      req = 2'b10; req_data = 32'h0055_0000; two = 2'b00;
      tick;
      chk("t5_regnt", 32'(gnt), 32'h2);
      chk("t5_pd", 32'(p_data), 32'h55);
      req = '0;
      tick;
      tx_busy = 1'b1;
      tick;
      tx_busy = 1'b0;
      tick;
      chk("t5_done", 32'(done), 32'h2);
      // request while transmitter busy in IDLE
      tx_busy = 1'b1; req = 2'b01; req_data = 32'h0000_00C3; two = 2'b00;
      dv_n = 0;
      for (int k = 0; k < 3; k++) begin
         tick;
         dv_n += int'(|gnt) + int'(ctrl_busy);
      end
      chk("t6_hold", 32'(dv_n), 0);
      tx_busy = 1'b0;
      tick;
      chk("t6_gnt", 32'(gnt), 32'h1);
      chk("t6_dv", 32'(dv), 1);
      chk("t6_pd", 32'(p_data), 32'hC3);
      req = '0;
      tick;
      tx_busy = 1'b1;
      tick;
      tx_busy = 1'b0;
      tick;
      chk("t6_done", 32'(done), 32'h1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
